// File: rtl/hockey_pkg.sv
// hockey_pkg: court geometry and coordinate helpers shared with the hockey core.
package hockey_pkg;
  localparam int COURT_ROWS = 5;
  localparam int COURT_COLS = 5;
  localparam int COORD_W = 3;
  function automatic logic on_court(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y,
                                    input int cols = COURT_COLS, input int rows = COURT_ROWS);
    return int'(x) < cols && int'(y) < rows;
  endfunction
endpackage

// File: rtl/scan_timer.sv
// scan_timer: row-slot, row and frame counters for the multiplexed court scan.
module scan_timer #(
  parameter int ROWS = 5,
  parameter int SCAN_DIV = 1000,
  parameter int BLANK = 2,
  parameter int BLINK_FRAMES = 25,
  parameter int RW = $clog2(ROWS + 1),
  parameter int FW = $clog2(BLINK_FRAMES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [RW-1:0] row_o,
  output logic [FW-1:0] fcnt_o,
  output logic          pcnt_blank_o,
  output logic          frame_start_o,
  output logic          frame_end_o
);
  localparam int PW = $clog2(SCAN_DIV + 1);
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [RW-1:0] row_q, row_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic pcnt_wrap;
  always_comb begin
    pcnt_wrap = pcnt_q == PW'(SCAN_DIV - 1);
    frame_end_o = pcnt_wrap && row_q == RW'(ROWS - 1);
    pcnt_d = pcnt_wrap ? '0 : pcnt_q + 1'b1;
    row_d = frame_end_o ? '0 : pcnt_wrap ? row_q + 1'b1 : row_q;
    fcnt_d = !frame_end_o ? fcnt_q : fcnt_q == FW'(BLINK_FRAMES - 1) ? '0 : fcnt_q + 1'b1;
    // Held reset forces the decodes dark even though the counters already sit at frame start.
    pcnt_blank_o = rst || int'(pcnt_q) < BLANK;
    frame_start_o = !rst && row_q == '0 && pcnt_q == '0;
    row_o = row_q;
    fcnt_o = fcnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pcnt_q <= '0;
      row_q <= '0;
      fcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      row_q <= row_d;
      fcnt_q <= fcnt_d;
    end
endmodule

// File: rtl/court_display_driver.sv
// court_display_driver: renders the puck with a dim trail on a row-scanned LED court;
// positions are latched at frame end and off-court positions flash the whole court.
module court_display_driver import hockey_pkg::*; #(
  parameter int ROWS = COURT_ROWS,
  parameter int COLS = COURT_COLS,
  parameter int SCAN_DIV = 1000,
  parameter int BLANK = 2,
  parameter int BLINK_FRAMES = 25
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] X_COORD,
  input  logic [COORD_W-1:0] Y_COORD,
  output logic [ROWS-1:0]    row_sel,
  output logic [COLS-1:0]    col_drv,
  output logic               frame_start
);
  localparam int RW = $clog2(ROWS + 1);
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  logic [RW-1:0] row;
  logic [FW-1:0] fcnt;
  logic blank, frame_end;
  logic [2*COORD_W-1:0] cur_q, cur_d, prev_q, prev_d, new_pos;
  logic cur_valid_q, cur_valid_d, prev_valid_q, prev_valid_d, moved;
  logic [COORD_W-1:0] cx, cy, px, py;
  logic [COLS-1:0] cur_bits, trail_bits;
  scan_timer #(
    .ROWS(ROWS), .SCAN_DIV(SCAN_DIV), .BLANK(BLANK), .BLINK_FRAMES(BLINK_FRAMES), .RW(RW), .FW(FW)
  ) u_timer (
    .clk(clk), .rst(rst), .row_o(row), .fcnt_o(fcnt), .pcnt_blank_o(blank),
    .frame_start_o(frame_start), .frame_end_o(frame_end)
  );
  always_comb begin
    new_pos = {X_COORD, Y_COORD};
    moved = frame_end && cur_valid_q && new_pos != cur_q;
    cur_d = frame_end ? new_pos : cur_q;
    cur_valid_d = cur_valid_q || frame_end;
    prev_d = moved ? cur_q : prev_q;
    prev_valid_d = prev_valid_q || moved;
    {cx, cy} = cur_q;
    {px, py} = prev_q;
    cur_bits = int'(cy) == int'(row) ? COLS'(1) << cx : '0;
    // Trail lights only on odd frames, giving it half the brightness of the puck.
    trail_bits = prev_valid_q && on_court(px, py, COLS, ROWS) && fcnt[0] && int'(py) == int'(row)
               ? COLS'(1) << px : '0;
    row_sel = blank ? '0 : ROWS'(1) << row;
    col_drv = blank || !cur_valid_q ? '0
            : !on_court(cx, cy, COLS, ROWS) ? (int'(fcnt) < BLINK_FRAMES / 2 ? '1 : '0)
            : cur_bits | trail_bits;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cur_q <= '0;
      prev_q <= '0;
      cur_valid_q <= 1'b0;
      prev_valid_q <= 1'b0;
    end else begin
      cur_q <= cur_d;
      prev_q <= prev_d;
      cur_valid_q <= cur_valid_d;
      prev_valid_q <= prev_valid_d;
    end
endmodule

// File: tb/tb_court_display_driver.sv
// tb_court_display_driver: randomized and directed checks against a cycle-count reference model.
module tb_court_display_driver;
  logic clk = 0, rst = 1;
  logic [2:0] x = 0, y = 0;
  logic [4:0] row_sel, col_drv;
  logic frame_start;
  int checks = 0, errors = 0;
  int t;
  logic [5:0] m_cur, m_prev;
  bit m_cur_v, m_prev_v;

  always #5 clk = ~clk;

  court_display_driver #(.ROWS(5), .COLS(5), .SCAN_DIV(4), .BLANK(1), .BLINK_FRAMES(4)) dut (
    .clk(clk), .rst(rst), .X_COORD(x), .Y_COORD(y),
    .row_sel(row_sel), .col_drv(col_drv), .frame_start(frame_start)
  );

  // Expected {row_sel, col_drv, frame_start} derived from cycle t since reset release.
  function automatic logic [10:0] expv();
    int p = t % 4, r = (t % 20) / 4, fc = (t / 20) % 4;
    int cx = int'(m_cur[5:3]), cy = int'(m_cur[2:0]), px = int'(m_prev[5:3]), py = int'(m_prev[2:0]);
    logic [4:0] rs = 0, cd = 0;
    if (p >= 1) begin
      rs[r] = 1'b1;
      if (m_cur_v) begin
        if (cx >= 5 || cy >= 5) cd = fc < 2 ? 5'b11111 : 5'b00000;
        else begin
          if (cy == r) cd[cx] = 1'b1;
          if (m_prev_v && px < 5 && py < 5 && fc % 2 == 1 && py == r) cd[px] = 1'b1;
        end
      end
    end
    return {rs, cd, t % 20 == 0};
  endfunction

  task automatic model_reset();
    t = 0; m_cur = 0; m_prev = 0; m_cur_v = 0; m_prev_v = 0;
  endtask

  task automatic tick();
    if (t % 20 == 19) begin
      if (m_cur_v && {x, y} != m_cur) begin m_prev = m_cur; m_prev_v = 1; end
      m_cur = {x, y}; m_cur_v = 1;
    end
    t++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; x = 0; y = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({row_sel, col_drv, frame_start} !== 11'b0) begin
      errors++; $display("FAIL reset_hold got %b required 0", {row_sel, col_drv, frame_start});
    end
    rst = 0; model_reset(); #1;
    checks++;
    if (frame_start !== 1'b1) begin errors++; $display("FAIL first_frame_start got %b required 1", frame_start); end
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({row_sel, col_drv, frame_start} !== expv()) begin
        errors++; $display("FAIL dark_frame t=%0d got %b required %b", t, {row_sel, col_drv, frame_start}, expv());
      end
      if (i == 5) begin x = 2; y = 3; end
      tick();
    end
  endtask

  task automatic test_track();
    for (int i = 0; i < 80; i++) begin
      checks++;
      if ({row_sel, col_drv, frame_start} !== expv()) begin
        errors++; $display("FAIL track t=%0d got %b required %b", t, {row_sel, col_drv, frame_start}, expv());
      end
      if (t == 33 || t == 73) begin
        checks++;
        if (col_drv !== 5'b00100) begin errors++; $display("FAIL row3_spot t=%0d got %b required 00100", t, col_drv); end
      end
      if (t == 41 || t == 61) begin
        checks++;
        if (col_drv !== 5'b10000) begin errors++; $display("FAIL row0_spot t=%0d got %b required 10000", t, col_drv); end
      end
      if (t == 53 || t == 93) begin
        checks++;
        if (col_drv !== 5'b00000) begin errors++; $display("FAIL no_trail t=%0d got %b required 00000", t, col_drv); end
      end
      if (i == 10) begin x = 4; y = 0; end
      tick();
    end
  endtask

  task automatic test_offcourt();
    x = 7; y = 0;
    for (int i = 0; i < 100; i++) begin
      checks++;
      if ({row_sel, col_drv, frame_start} !== expv()) begin
        errors++; $display("FAIL offcourt t=%0d got %b required %b", t, {row_sel, col_drv, frame_start}, expv());
      end
      if (t == 161 || t == 189) begin
        checks++;
        if (col_drv !== 5'b11111) begin errors++; $display("FAIL flash_on t=%0d got %b required 11111", t, col_drv); end
      end
      if (t == 121 || t == 141) begin
        checks++;
        if (col_drv !== 5'b00000) begin errors++; $display("FAIL flash_off t=%0d got %b required 00000", t, col_drv); end
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      checks++;
      if ({row_sel, col_drv, frame_start} !== expv()) begin
        errors++; $display("FAIL random t=%0d got %b required %b", t, {row_sel, col_drv, frame_start}, expv());
      end
      if ($urandom_range(7, 0) == 0) begin
        x = 3'($urandom_range(7, 0));
        y = 3'($urandom_range(7, 0));
      end
      tick();
    end
  endtask

  task automatic test_mid_reset();
    x = 1; y = 1;
    for (int i = 0; i < 40 && t % 20 != 9; i++) tick();
    checks++;
    if (t % 20 != 9) begin errors++; $display("FAIL reach_row2 t=%0d required slot 9", t); end
    rst = 1; #1;
    checks++;
    if ({row_sel, col_drv, frame_start} !== 11'b0) begin
      errors++; $display("FAIL async_reset got %b required 0", {row_sel, col_drv, frame_start});
    end
    repeat (2) @(negedge clk);
    rst = 0; model_reset(); #1;
    checks++;
    if (frame_start !== 1'b1) begin errors++; $display("FAIL restart_frame_start got %b required 1", frame_start); end
    for (int i = 0; i < 40; i++) begin
      checks++;
      if ({row_sel, col_drv, frame_start} !== expv()) begin
        errors++; $display("FAIL restart t=%0d got %b required %b", t, {row_sel, col_drv, frame_start}, expv());
      end
      if (t == 27) begin
        checks++;
        if (col_drv !== 5'b00010) begin errors++; $display("FAIL restart_pos t=%0d got %b required 00010", t, col_drv); end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_track();
    test_offcourt();
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
